// File: rtl/dkong_video_timing.sv
// Parametrised H/V video timing generator with clock-enable divider and frame-latched offsets/flip.
// Optional horizontal flip shadow: define DKONG_VT_HFLIP_EN.
module dkong_video_timing #(
  parameter int CLK_DIV      = 2,
  parameter int HW           = 9,
  parameter int VW           = 9,
  parameter int H_TOTAL      = 384,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 288,
  parameter int H_SYNC_WIDTH = 32,
  parameter int V_TOTAL      = 264,
  parameter int V_ACTIVE     = 224,
  parameter int V_SYNC_START = 240,
  parameter int V_SYNC_WIDTH = 8
) (
  input  logic          I_CLK,
  input  logic          RST_n,
  input  logic          V_FLIP,
  input  logic          H_FLIP,
  input  logic [HW-1:0] H_OFFSET,
  input  logic [VW-1:0] V_OFFSET,
  output logic          O_CLK,
  output logic          O_CLK_EN,
  output logic [HW-1:0] H_CNT,
  output logic [VW-1:0] V_CNT,
  output logic [VW-1:0] VF_CNT,
  output logic [HW-1:0] HF_CNT,
  output logic          H_BLANKn,
  output logic          V_BLANKn,
  output logic          C_BLANKn,
  output logic          H_SYNCn,
  output logic          V_SYNCn,
  output logic          LINE_STB,
  output logic          FRAME_STB
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CEN_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CEN_HALF = CW'(CLK_DIV / 2);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW:0]   H_TOT  = (HW+1)'(H_TOTAL);
  localparam logic [HW:0]   H_ACT  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   H_SS   = (HW+1)'(H_SYNC_START);
  localparam logic [HW:0]   H_SW   = (HW+1)'(H_SYNC_WIDTH);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW:0]   V_TOT  = (VW+1)'(V_TOTAL);
  localparam logic [VW:0]   V_ACT  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   V_SS   = (VW+1)'(V_SYNC_START);
  localparam logic [VW:0]   V_SW   = (VW+1)'(V_SYNC_WIDTH);

  logic [CW-1:0] cen_q, cen_d;
  logic [HW-1:0] h_q, h_d, hoff_q, hoff_d;
  logic [VW-1:0] v_q, v_d, voff_q, voff_d;
  logic          vflip_q, vflip_d;
  logic          line_stb_q, line_stb_d, frame_stb_q, frame_stb_d;
  logic          hblank_q, hblank_d, vblank_q, vblank_d, cblank_q, cblank_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          en, h_wrap, f_wrap;
  logic [HW:0]   hs, hdiff;
  logic [VW:0]   vs, vdiff;

`ifdef DKONG_VT_HFLIP_EN
  logic hflip_q, hflip_d;
`endif

  always_comb begin
    en     = (cen_q == CEN_LAST);
    cen_d  = en ? '0 : cen_q + 1'b1;
    h_wrap = en && (h_q == H_LAST);
    f_wrap = h_wrap && (v_q == V_LAST);

    h_d = h_q;
    if (en) h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;

    hoff_d  = hoff_q;
    voff_d  = voff_q;
    vflip_d = vflip_q;
`ifdef DKONG_VT_HFLIP_EN
    hflip_d = hflip_q;
`endif
    if (f_wrap) begin
      hoff_d  = ({1'b0, H_OFFSET} >= H_TOT) ? H_LAST : H_OFFSET;
      voff_d  = ({1'b0, V_OFFSET} >= V_TOT) ? V_LAST : V_OFFSET;
      vflip_d = V_FLIP;
`ifdef DKONG_VT_HFLIP_EN
      hflip_d = H_FLIP;
`endif
    end

    // Decodes use next-state counters and shadows so registered outputs line up with H_CNT/V_CNT.
    hs = H_SS + {1'b0, hoff_d};
    if (hs >= H_TOT) hs = hs - H_TOT;
    vs = V_SS + {1'b0, voff_d};
    if (vs >= V_TOT) vs = vs - V_TOT;
    hdiff = ({1'b0, h_d} >= hs) ? {1'b0, h_d} - hs : {1'b0, h_d} + H_TOT - hs;
    vdiff = ({1'b0, v_d} >= vs) ? {1'b0, v_d} - vs : {1'b0, v_d} + V_TOT - vs;

    hblank_d    = ({1'b0, h_d} < H_ACT);
    vblank_d    = ({1'b0, v_d} < V_ACT);
    cblank_d    = hblank_d & vblank_d;
    hsync_d     = !(hdiff < H_SW);
    vsync_d     = !(vdiff < V_SW);
    line_stb_d  = h_wrap;
    frame_stb_d = f_wrap;
  end

  always_ff @(posedge I_CLK or negedge RST_n) begin
    if (!RST_n) begin
      cen_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      hoff_q      <= '0;
      voff_q      <= '0;
      vflip_q     <= 1'b0;
      line_stb_q  <= 1'b0;
      frame_stb_q <= 1'b0;
      hblank_q    <= 1'b1;
      vblank_q    <= 1'b1;
      cblank_q    <= 1'b1;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      cen_q       <= cen_d;
      h_q         <= h_d;
      v_q         <= v_d;
      hoff_q      <= hoff_d;
      voff_q      <= voff_d;
      vflip_q     <= vflip_d;
      line_stb_q  <= line_stb_d;
      frame_stb_q <= frame_stb_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      cblank_q    <= cblank_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

`ifdef DKONG_VT_HFLIP_EN
  always_ff @(posedge I_CLK or negedge RST_n) begin
    if (!RST_n) hflip_q <= 1'b0;
    else        hflip_q <= hflip_d;
  end
  assign HF_CNT = h_q ^ {HW{hflip_q}};
`else
  logic unused_hflip;
  assign unused_hflip = H_FLIP;
  assign HF_CNT       = h_q;
`endif

  assign O_CLK     = (cen_q >= CEN_HALF);
  assign O_CLK_EN  = en;
  assign H_CNT     = h_q;
  assign V_CNT     = v_q;
  assign VF_CNT    = v_q ^ {VW{vflip_q}};
  assign H_BLANKn  = hblank_q;
  assign V_BLANKn  = vblank_q;
  assign C_BLANKn  = cblank_q;
  assign H_SYNCn   = hsync_q;
  assign V_SYNCn   = vsync_q;
  assign LINE_STB  = line_stb_q;
  assign FRAME_STB = frame_stb_q;

endmodule

// File: tb/tb_dkong_video_timing.sv
// Directed bench for dkong_video_timing: default H geometry, shortened frame (10 lines) to keep runs short.
module tb_dkong_video_timing;

  localparam int LINE_CLKS  = 768;
  localparam int FRAME_CLKS = 7680;
`ifdef DKONG_VT_HFLIP_EN
  localparam bit HF_ON = 1'b1;
`else
  localparam bit HF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, v_flip, h_flip;
  logic [8:0] h_off, v_off;
  logic       o_clk, o_clk_en;
  logic [8:0] h_cnt, v_cnt, vf_cnt, hf_cnt;
  logic       h_blankn, v_blankn, c_blankn, h_syncn, v_syncn, line_stb, frame_stb;

  int total = 0;
  int bad   = 0;
  int since_rel;

  always #5 clk = ~clk;

  dkong_video_timing #(
    .V_TOTAL(10), .V_ACTIVE(6), .V_SYNC_START(7), .V_SYNC_WIDTH(2)
  ) dut (
    .I_CLK(clk), .RST_n(rst_n), .V_FLIP(v_flip), .H_FLIP(h_flip),
    .H_OFFSET(h_off), .V_OFFSET(v_off),
    .O_CLK(o_clk), .O_CLK_EN(o_clk_en), .H_CNT(h_cnt), .V_CNT(v_cnt),
    .VF_CNT(vf_cnt), .HF_CNT(hf_cnt), .H_BLANKn(h_blankn), .V_BLANKn(v_blankn),
    .C_BLANKn(c_blankn), .H_SYNCn(h_syncn), .V_SYNCn(v_syncn),
    .LINE_STB(line_stb), .FRAME_STB(frame_stb)
  );

  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_stb !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (frame_stb !== 1'b1) begin
      bad++;
      $display("FAIL %s_wait_frame got=timeout required=FRAME_STB", tag);
    end
  endtask

  task automatic wait_line(input int vv, input string tag);
    int n = 0;
    while (!(line_stb === 1'b1 && v_cnt === 9'(vv)) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!(line_stb === 1'b1 && v_cnt === 9'(vv))) begin
      bad++;
      $display("FAIL %s_wait_line got=timeout required=line %0d", tag, vv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v_flip = 1'b0; h_flip = 1'b0; h_off = '0; v_off = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_clk, o_clk_en, line_stb, frame_stb} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_clk_stb got=%b required=0000", {o_clk, o_clk_en, line_stb, frame_stb});
    end
    total++;
    if ({h_blankn, v_blankn, c_blankn, h_syncn, v_syncn} !== 5'b11111) begin
      bad++;
      $display("FAIL rst_n_outs got=%b required=11111", {h_blankn, v_blankn, c_blankn, h_syncn, v_syncn});
    end
    total++;
    if ({h_cnt, v_cnt, vf_cnt, hf_cnt} !== 36'd0) begin
      bad++;
      $display("FAIL rst_counters got=%h required=0", {h_cnt, v_cnt, vf_cnt, hf_cnt});
    end
    rst_n = 1'b1;
    since_rel = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      since_rel++;
      total++;
      if ({o_clk, o_clk_en} !== {2{k[0]}}) begin
        bad++;
        $display("FAIL clk_en_pattern k=%0d got=%b required=%b", k, {o_clk, o_clk_en}, {2{k[0]}});
      end
    end
    total++;
    if (h_cnt !== 9'd4) begin
      bad++;
      $display("FAIL early_hcnt got=%0d required=4", h_cnt);
    end
  endtask

  task automatic test_line();
    logic [8:0] prev_h;
    prev_h = h_cnt;
    while (line_stb !== 1'b1 && since_rel < 2000) begin
      prev_h = h_cnt;
      @(negedge clk);
      since_rel++;
    end
    total++;
    if (since_rel !== LINE_CLKS) begin
      bad++;
      $display("FAIL first_line_stb got=%0d required=%0d", since_rel, LINE_CLKS);
    end
    total++;
    if ({prev_h, h_cnt, v_cnt} !== {9'd383, 9'd0, 9'd1}) begin
      bad++;
      $display("FAIL h_wrap got=%0d->%0d v=%0d required=383->0 v=1", prev_h, h_cnt, v_cnt);
    end
    @(negedge clk);
    total++;
    if (line_stb !== 1'b0) begin
      bad++;
      $display("FAIL line_stb_width got=%b required=0", line_stb);
    end
  endtask

  task automatic test_sync_default();
    int h, v;
    logic [24:0] got, exp;
    wait_frame("default");
    for (int i = 0; i < FRAME_CLKS; i++) begin
      h = (i / 2) % 384;
      v = i / LINE_CLKS;
      exp = {h[8:0], v[8:0], h < 256, v < 6, (h < 256) && (v < 6),
             !(h >= 288 && h < 320), !(v >= 7 && v <= 8), (i % LINE_CLKS) == 0, i == 0};
      got = {h_cnt, v_cnt, h_blankn, v_blankn, c_blankn, h_syncn, v_syncn, line_stb, frame_stb};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL default_frame i=%0d got=%h required=%h", i, got, exp);
      end
      @(negedge clk);
    end
    total++;
    if (frame_stb !== 1'b1) begin
      bad++;
      $display("FAIL frame_period got=%b required=1 after %0d clks", frame_stb, FRAME_CLKS);
    end
  endtask

  task automatic test_hsync_wrap();
    int h;
    h_off = 9'd80;
    @(negedge clk);
    wait_frame("hwrap");
    h_off = 9'd500;
    for (int i = 0; i < LINE_CLKS; i++) begin
      h = i / 2;
      total++;
      if (h_syncn !== !(h >= 368 || h < 16)) begin
        bad++;
        $display("FAIL hsync_wrap h=%0d got=%b required=%b", h, h_syncn, !(h >= 368 || h < 16));
      end
      @(negedge clk);
    end
    wait_frame("hclamp");
    for (int i = 0; i < LINE_CLKS; i++) begin
      h = i / 2;
      total++;
      if (h_syncn !== !(h >= 287 && h <= 318)) begin
        bad++;
        $display("FAIL hsync_clamp h=%0d got=%b required=%b", h, h_syncn, !(h >= 287 && h <= 318));
      end
      @(negedge clk);
    end
    h_off = '0;
  endtask

  task automatic test_voffset();
    int line, v;
    logic exp;
    wait_line(3, "voff");
    v_off = 9'd2;
    for (int i = 0; i < 7 * LINE_CLKS + FRAME_CLKS; i++) begin
      line = 3 + i / LINE_CLKS;
      v = line % 10;
      exp = (line < 10) ? !(v == 7 || v == 8) : !(v == 9 || v == 0);
      total++;
      if ({v_cnt, v_syncn} !== {v[8:0], exp}) begin
        bad++;
        $display("FAIL voffset i=%0d got v=%0d vs=%b required v=%0d vs=%b", i, v_cnt, v_syncn, v, exp);
      end
      @(negedge clk);
    end
    v_off = '0;
  endtask

  task automatic test_flip();
    int line, v, h;
    logic [8:0] evf, ehf;
    wait_line(3, "flip");
    v_flip = 1'b1;
    h_flip = 1'b1;
    for (int i = 0; i < 9 * LINE_CLKS; i++) begin
      line = 3 + i / LINE_CLKS;
      v = line % 10;
      h = (i / 2) % 384;
      evf = (line >= 10) ? (v[8:0] ^ 9'h1FF) : v[8:0];
      ehf = (line >= 10 && HF_ON) ? (h[8:0] ^ 9'h1FF) : h[8:0];
      total++;
      if ({vf_cnt, hf_cnt} !== {evf, ehf}) begin
        bad++;
        $display("FAIL flip i=%0d got vf=%0d hf=%0d required vf=%0d hf=%0d", i, vf_cnt, hf_cnt, evf, ehf);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(h_cnt === 9'd200 && v_cnt === 9'd5) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!(h_cnt === 9'd200 && v_cnt === 9'd5)) begin
      bad++;
      $display("FAIL rstmid_wait got=timeout required=H200 V5");
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({h_cnt, v_cnt, vf_cnt, hf_cnt, o_clk, o_clk_en, line_stb, frame_stb} !== 40'd0) begin
      bad++;
      $display("FAIL rstmid_async got=%h required=0", {h_cnt, v_cnt, vf_cnt, hf_cnt, o_clk, o_clk_en, line_stb, frame_stb});
    end
    total++;
    if ({h_blankn, v_blankn, c_blankn, h_syncn, v_syncn} !== 5'b11111) begin
      bad++;
      $display("FAIL rstmid_n_outs got=%b required=11111", {h_blankn, v_blankn, c_blankn, h_syncn, v_syncn});
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (line_stb !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== LINE_CLKS) begin
      bad++;
      $display("FAIL rstmid_line_stb got=%0d required=%0d", n, LINE_CLKS);
    end
    total++;
    if ({v_cnt, vf_cnt} !== {9'd1, 9'd1}) begin
      bad++;
      $display("FAIL rstmid_vflip_cleared got v=%0d vf=%0d required v=1 vf=1", v_cnt, vf_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_sync_default();
    test_hsync_wrap();
    test_voffset();
    test_flip();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dkong_video_timing.md
Name: dkong_video_timing

Overview:
Parametrised video timing generator. Replaces the fixed-geometry H/V counter with one that has configurable geometry and a clock-enable divider. Produces the pixel clock and enable, H/V counters, flipped V counter, blanking, sync, and line/frame strobes. Runtime offsets and flip are shadow-latched at frame start, so they never tear mid-frame. Sits at the top of the video path and feeds the tile, sprite and palette blocks and the scan-doubler.

Parameters:
CLK_DIV, 2, I_CLK cycles per pixel (≥2)
HW, 9, width of H counter
VW, 9, width of V counter
H_TOTAL, 384, pixels per line
H_ACTIVE, 256, visible pixels (H_CNT 0..H_ACTIVE-1)
H_SYNC_START, 288, nominal hsync start pixel
H_SYNC_WIDTH, 32, hsync length in pixels
V_TOTAL, 264, lines per frame
V_ACTIVE, 224, visible lines
V_SYNC_START, 240, nominal vsync start line
V_SYNC_WIDTH, 8, vsync length in lines

Ports:
I_CLK in 1 master clock
RST_n in 1 reset, asynchronous, active-low
V_FLIP in 1 vertical flip request
H_FLIP in 1 horizontal flip request (optional feature)
H_OFFSET in HW sync shift in pixels
V_OFFSET in VW sync shift in lines
O_CLK out 1 pixel clock (divided)
O_CLK_EN out 1 one-I_CLK pulse per pixel
H_CNT out HW pixel counter
V_CNT out VW line counter
VF_CNT out VW flipped line counter
HF_CNT out HW flipped pixel counter
H_BLANKn, V_BLANKn, C_BLANKn out 1 each, blanking (low = blank)
H_SYNCn, V_SYNCn out 1 each, sync (low = active)
LINE_STB, FRAME_STB out 1 each, start-of-line / start-of-frame pulses

Behaviour:
- Reset values: all counters 0; shadow offsets 0; shadow flips 0; O_CLK=0; O_CLK_EN=0; strobes 0; all *n outputs 1.
- Divider: cen_cnt counts 0..CLK_DIV-1 and wraps. O_CLK = (cen_cnt ≥ CLK_DIV/2). O_CLK_EN = (cen_cnt == CLK_DIV-1).
- All other state advances only on I_CLK edges where O_CLK_EN=1.
- H_CNT: increments; at H_TOTAL-1 wraps to 0.
- V_CNT: increments when H wraps; at V_TOTAL-1 (with H wrap) wraps to 0.
- LINE_STB=1 on the cycle after the H wrap edge, for exactly 1 I_CLK.
- FRAME_STB: same timing, at the frame wrap only.
- Shadow load: on the frame-wrap edge, latch H_OFFSET, V_OFFSET, V_FLIP and H_FLIP.
  - An offset ≥ its TOTAL is clamped to TOTAL-1.
  - Offset changes mid-frame have no effect until the next frame.
- Effective sync start: hs = (H_SYNC_START+h_off) mod H_TOTAL; vs = (V_SYNC_START+v_off) mod V_TOTAL.
  - The sync window is [start, start+WIDTH) modulo TOTAL.
  - A window may wrap past TOTAL-1 and must assert across the wrap.
- Decoded outputs are registered. They are computed from the next counter value, so they are aligned with H_CNT/V_CNT (zero latency):
  - H_BLANKn = H_CNT < H_ACTIVE
  - V_BLANKn = V_CNT < V_ACTIVE
  - C_BLANKn = H_BLANKn & V_BLANKn
  - H_SYNCn = !(H_CNT in h window)
  - V_SYNCn = !(V_CNT in v window); changes only at H_CNT==0
- VF_CNT = V_CNT XOR {VW{v_flip_shadow}}.
- Reset mid-frame: immediate asynchronous return to reset values. Counting resumes from 0,0 on the first edge after deassertion.

Optional Feature:
DKONG_VT_HFLIP_EN
- Defined: HF_CNT = H_CNT XOR {HW{h_flip_shadow}}; H_FLIP is shadow-latched as above.
- Undefined: HF_CNT = H_CNT; H_FLIP is ignored and the h_flip shadow register is not built.

Test Plan:
- Reset release, defaults: O_CLK_EN pulses every 2nd I_CLK; H_CNT 383→0 with LINE_STB; FRAME_STB period 202752 I_CLK (384×264×2).
- Offsets 0: H_SYNCn low for H_CNT 288..319; V_SYNCn low for V_CNT 240..247, toggling at H_CNT=0; H_BLANKn low at H_CNT 256..383; V_BLANKn low at V_CNT 224..263.
- Wrap-around: H_OFFSET=80 → H_SYNCn low for H_CNT 368..383 and 0..15. H_OFFSET=500 → clamped to 383, sync low at 287..318.
- Mid-frame V_OFFSET 0→10 at V_CNT=100: current frame vsync stays at 240..247; next frame 250..257.
- V_FLIP=1 at V_CNT=50: VF_CNT==V_CNT until FRAME_STB, then VF_CNT==~V_CNT (V_CNT=0 → 511). With DKONG_VT_HFLIP_EN and H_FLIP=1, the next frame gives HF_CNT=511 at H_CNT=0; without the macro, HF_CNT==H_CNT always.
- RST_n pulsed low at H=200,V=120: outputs go to reset values asynchronously; after release, the first LINE_STB comes 768 I_CLK later.
